// File: rtl/cronometro_pkg.sv
// Shared constants and BCD helpers for the MM.SS stopwatch.
// Rev 1.0
`default_nettype none

package cronometro_pkg;

  localparam int MAX_MIN = 99;
  localparam int MAX_SEC = 59;

  localparam logic [7:0] AN_IDLE = 8'hFF;

  // Active-low {a,b,c,d,e,f,g,dp}, dp off.
  localparam logic [7:0] SEG_0     = 8'h03;
  localparam logic [7:0] SEG_1     = 8'h9F;
  localparam logic [7:0] SEG_2     = 8'h25;
  localparam logic [7:0] SEG_3     = 8'h0D;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h49;
  localparam logic [7:0] SEG_6     = 8'h41;
  localparam logic [7:0] SEG_7     = 8'h1F;
  localparam logic [7:0] SEG_8     = 8'h01;
  localparam logic [7:0] SEG_9     = 8'h09;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic [1:0] {
    DIG_SEC_U = 2'd0,
    DIG_SEC_T = 2'd1,
    DIG_MIN_U = 2'd2,
    DIG_MIN_T = 2'd3
  } digit_e;

  // Clamp to 0..99 and convert to two packed BCD digits.
  function automatic logic [7:0] bin_to_bcd(input logic [6:0] v);
    logic [6:0] c;
    logic [6:0] t;
    logic [6:0] u;
    c = (v > 7'(MAX_MIN)) ? 7'(MAX_MIN) : v;
    t = c / 7'd10;
    u = c % 7'd10;
    return {t[3:0], u[3:0]};
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

endpackage

`default_nettype wire

// File: rtl/cronometro_seg7_dec.sv
// seg7_dec: BCD digit plus dp enable to active-low segment pattern.
// Rev 1.0
`default_nettype none

module seg7_dec
  import cronometro_pkg::*;
(
  input  logic [3:0] bcd_i,
  input  logic       dp_en_i,
  output logic [7:0] dec_ddp_o
);

  logic [7:0] seg_code;

  always_comb begin
    seg_code = SEG_BLANK;
    case (bcd_i)
      4'd0:    seg_code = SEG_0;
      4'd1:    seg_code = SEG_1;
      4'd2:    seg_code = SEG_2;
      4'd3:    seg_code = SEG_3;
      4'd4:    seg_code = SEG_4;
      4'd5:    seg_code = SEG_5;
      4'd6:    seg_code = SEG_6;
      4'd7:    seg_code = SEG_7;
      4'd8:    seg_code = SEG_8;
      4'd9:    seg_code = SEG_9;
      default: seg_code = SEG_BLANK;
    endcase
  end

  assign dec_ddp_o = {seg_code[7:1], seg_code[0] & ~dp_en_i};

endmodule

`default_nettype wire

// File: rtl/cronometro_top.sv
// cronometro_top: loadable MM.SS stopwatch with a 4-digit multiplexed display.
// Rev 1.0
`default_nettype none

module cronometro_top
  import cronometro_pkg::*;
#(
  parameter int CLOCK_FREQ = 100_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       carga,
  input  logic       conta,
  input  logic [6:0] chaves,
  output logic [7:0] an,
  output logic [7:0] dec_ddp
);

  localparam int SCAN_DIV = ((CLOCK_FREQ / 4000) >= 1) ? (CLOCK_FREQ / 4000) : 1;
  localparam int PW       = (CLOCK_FREQ > 1) ? $clog2(CLOCK_FREQ) : 1;
  localparam int DW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [PW-1:0] PRESC_MAX = PW'(CLOCK_FREQ - 1);
  localparam logic [DW-1:0] DIV_MAX   = DW'(SCAN_DIV - 1);
  localparam logic [7:0]    MIN_TOP   = bin_to_bcd(7'(MAX_MIN));
  localparam logic [7:0]    SEC_TOP   = bin_to_bcd(7'(MAX_SEC));

  logic [7:0]    min_q, min_d;
  logic [7:0]    sec_q, sec_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [DW-1:0] div_q;
  digit_e        scan_q;
  logic [7:0]    an_q, an_d;
  logic [7:0]    dec_q;

  logic [3:0]    digit_bcd;
  logic          dp_en;
  logic [7:0]    seg_code;

  // Load beats count; the tick saturates at 99:59 while presc keeps wrapping.
  always_comb begin
    min_d   = min_q;
    sec_d   = sec_q;
    presc_d = presc_q;
    if (carga) begin
      min_d   = bin_to_bcd(chaves);
      sec_d   = 8'h00;
      presc_d = '0;
    end else if (conta) begin
      if (presc_q == PRESC_MAX) begin
        presc_d = '0;
        if (!(min_q == MIN_TOP && sec_q == SEC_TOP)) begin
          if (sec_q == SEC_TOP) begin
            sec_d = 8'h00;
            min_d = bcd_inc(min_q);
          end else begin
            sec_d = bcd_inc(sec_q);
          end
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  always_comb begin
    digit_bcd = sec_q[3:0];
    dp_en     = 1'b0;
    an_d      = AN_IDLE;
    case (scan_q)
      DIG_SEC_U: begin digit_bcd = sec_q[3:0]; an_d = 8'hFE; end
      DIG_SEC_T: begin digit_bcd = sec_q[7:4]; an_d = 8'hFD; end
      DIG_MIN_U: begin digit_bcd = min_q[3:0]; an_d = 8'hFB; dp_en = 1'b1; end
      DIG_MIN_T: begin digit_bcd = min_q[7:4]; an_d = 8'hF7; end
      default:   begin digit_bcd = sec_q[3:0]; an_d = AN_IDLE; end
    endcase
  end

  seg7_dec u_seg7_dec (
    .bcd_i     (digit_bcd),
    .dp_en_i   (dp_en),
    .dec_ddp_o (seg_code)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      min_q   <= 8'h00;
      sec_q   <= 8'h00;
      presc_q <= '0;
      div_q   <= '0;
      scan_q  <= DIG_SEC_U;
      an_q    <= AN_IDLE;
      dec_q   <= SEG_BLANK;
    end else begin
      min_q   <= min_d;
      sec_q   <= sec_d;
      presc_q <= presc_d;
      an_q    <= an_d;
      dec_q   <= seg_code;
      if (div_q == DIV_MAX) begin
        div_q  <= '0;
        scan_q <= digit_e'(scan_q + 2'd1);
      end else begin
        div_q  <= div_q + DW'(1);
      end
    end
  end

  assign an      = an_q;
  assign dec_ddp = dec_q;

endmodule

`default_nettype wire

// File: tb/tb_cronometro_top.sv
// Directed bench for cronometro_top at CLOCK_FREQ=4.
// Rev 1.0
`default_nettype none

module tb_cronometro_top;

  logic       clock = 1'b0;
  logic       reset;
  logic       carga;
  logic       conta;
  logic [6:0] chaves;
  logic [7:0] an;
  logic [7:0] dec_ddp;

  int n_chk  = 0;
  int n_pass = 0;

  localparam logic [7:0] SEGS [0:9] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99,
                                        8'h49, 8'h41, 8'h1F, 8'h01, 8'h09};

  cronometro_top #(.CLOCK_FREQ(4)) dut (
    .clock   (clock),
    .reset   (reset),
    .carga   (carga),
    .conta   (conta),
    .chaves  (chaves),
    .an      (an),
    .dec_ddp (dec_ddp)
  );

  always #5 clock = ~clock;

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [7:0] seg(input logic [3:0] d, input logic dp);
    logic [7:0] c;
    c = SEGS[d];
    if (dp) c[0] = 1'b0;
    return c;
  endfunction

  // Let the display settle, then capture one full scan of the four digits.
  task automatic check_disp(input string tag, input logic [7:0] m, input logic [7:0] s);
    logic [7:0] got [4];
    logic [7:0] seen;
    step(6);
    seen = 8'h00;
    for (int i = 0; i < 4; i++) got[i] = 8'hxx;
    for (int i = 0; i < 4; i++) begin
      case (an)
        8'hFE:   begin got[0] = dec_ddp; seen[0] = 1'b1; end
        8'hFD:   begin got[1] = dec_ddp; seen[1] = 1'b1; end
        8'hFB:   begin got[2] = dec_ddp; seen[2] = 1'b1; end
        8'hF7:   begin got[3] = dec_ddp; seen[3] = 1'b1; end
        default: seen[7] = 1'b1;
      endcase
      step(1);
    end
    chk8({tag, "/scan"},  seen,   8'h0F);
    chk8({tag, "/sec_u"}, got[0], seg(s[3:0], 1'b0));
    chk8({tag, "/sec_t"}, got[1], seg(s[7:4], 1'b0));
    chk8({tag, "/min_u"}, got[2], seg(m[3:0], 1'b1));
    chk8({tag, "/min_t"}, got[3], seg(m[7:4], 1'b0));
  endtask

  initial begin
    reset  = 1'b0;
    carga  = 1'b0;
    conta  = 1'b0;
    chaves = 7'd0;

    step(7);
    chk8("rst/an",  an,      8'hFF);
    chk8("rst/dec", dec_ddp, 8'hFF);

    reset = 1'b1;
    step(1);
    chk8("rel0/an",  an,      8'hFE);
    chk8("rel0/dec", dec_ddp, 8'h03);
    step(1);
    chk8("rel1/an",  an,      8'hFD);
    chk8("rel1/dec", dec_ddp, 8'h03);
    step(1);
    chk8("rel2/an",  an,      8'hFB);
    chk8("rel2/dec", dec_ddp, 8'h02);
    step(1);
    chk8("rel3/an",  an,      8'hF7);
    chk8("rel3/dec", dec_ddp, 8'h03);

    chaves = 7'd5;
    carga  = 1'b1;
    step(29);
    carga  = 1'b0;
    check_disp("load5", 8'h05, 8'h00);

    conta = 1'b1;
    step(38);
    conta = 1'b0;
    check_disp("cnt38", 8'h05, 8'h09);
    step(10);
    check_disp("pause", 8'h05, 8'h09);

    // 38 cycles left presc at 2, so two more counting cycles finish the second.
    conta = 1'b1;
    step(2);
    conta = 1'b0;
    check_disp("resume", 8'h05, 8'h10);

    chaves = 7'd120;
    carga  = 1'b1;
    step(1);
    carga  = 1'b0;
    check_disp("clamp", 8'h99, 8'h00);

    conta = 1'b1;
    step(240);
    conta = 1'b0;
    check_disp("sat", 8'h99, 8'h59);
    conta = 1'b1;
    step(40);
    conta = 1'b0;
    check_disp("sat_hold", 8'h99, 8'h59);

    chaves = 7'd3;
    carga  = 1'b1;
    step(1);
    carga  = 1'b0;
    conta  = 1'b1;
    step(68);
    conta  = 1'b0;
    check_disp("at317", 8'h03, 8'h17);
    carga = 1'b1;
    conta = 1'b1;
    step(1);
    carga = 1'b0;
    conta = 1'b0;
    chk8("both/sec", dut.sec_q, 8'h00);
    chk8("both/min", dut.min_q, 8'h03);
    check_disp("both", 8'h03, 8'h00);

    chaves = 7'd12;
    carga  = 1'b1;
    step(1);
    carga  = 1'b0;
    conta  = 1'b1;
    step(136);
    chk8("at1234/min", dut.min_q, 8'h12);
    chk8("at1234/sec", dut.sec_q, 8'h34);
    reset = 1'b0;
    step(1);
    chk8("midrst/min", dut.min_q, 8'h00);
    chk8("midrst/sec", dut.sec_q, 8'h00);
    chk8("midrst/an",  an,        8'hFF);
    chk8("midrst/dec", dec_ddp,   8'hFF);
    reset = 1'b1;
    conta = 1'b0;
    step(1);
    chk8("restart/an", an, 8'hFE);
    check_disp("post_rst", 8'h00, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
